// File: rtl/conv_window_3x3.sv
// conv_window_3x3
// Streaming 3x3 sliding-window generator. It takes a raster-ordered pixel
// stream, one pixel per pix_valid cycle. Two line buffers and a 3x3 register
// window produce every fully populated neighbourhood ("valid" convolution),
// giving (IMG_H-2)*(IMG_W-2) windows per frame.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   pix_valid, pix_in input pixel strobe and data (row 0, col 0 first)
//   win_valid         win_data/win_row/win_col hold a complete window
//   win_data          9 pixels; slot 3*r+c = pixel (R-2+r, C-2+c)
//   win_row, win_col  top-left coordinate of the window
//   frame_done        pulses together with the last window of a frame
//
// Optional feature (macro CONV_WIN_CNT_EN):
//   win_cnt           windows emitted so far in the current frame
//   cnt_err           sticky; set when a frame ends with the wrong window count
module conv_window_3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [DATA_W-1:0]     pix_in,
    output logic                  win_valid,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [4:0]            win_row,
    output logic [4:0]            win_col,
    output logic                  frame_done
`ifdef CONV_WIN_CNT_EN
    ,
    output logic [9:0]            win_cnt,
    output logic                  cnt_err
`endif
);

    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);
    localparam int unsigned N_WIN = (IMG_H - 2) * (IMG_W - 2);

    typedef enum logic {
        S_FILL,
        S_STREAM
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    logic                col_end_c;
    logic                row_end_c;
    logic                emit_c;
    logic                last_c;
    logic [DATA_W-1:0]   lb0_rd_c;
    logic [DATA_W-1:0]   lb1_rd_c;
    logic [9*DATA_W-1:0] win_shift_c;

    // Next state and the emit/last decisions for the pixel being accepted.
    always_comb begin
        state_nxt = state;
        emit_c    = 1'b0;
        last_c    = 1'b0;
        col_end_c = (col == CW'(IMG_W - 1));
        row_end_c = (row == RW'(IMG_H - 1));
        case (state)
            S_FILL: begin
                if (pix_valid && col_end_c && (row == RW'(1))) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pix_valid && (col >= CW'(2))) begin
                    emit_c = 1'b1;
                end
                if (pix_valid && col_end_c && row_end_c) begin
                    last_c    = 1'b1;
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    // Window shifted left by one column; the new right column is rows R-2, R-1, R.
    always_comb begin
        lb0_rd_c    = lb0[col];
        lb1_rd_c    = lb1[col];
        win_shift_c = win_data;
        for (int r = 0; r < 3; r++) begin
            win_shift_c[DATA_W*(3*r)   +: DATA_W] = win_data[DATA_W*(3*r+1) +: DATA_W];
            win_shift_c[DATA_W*(3*r+1) +: DATA_W] = win_data[DATA_W*(3*r+2) +: DATA_W];
        end
        win_shift_c[DATA_W*2 +: DATA_W] = lb0_rd_c;
        win_shift_c[DATA_W*5 +: DATA_W] = lb1_rd_c;
        win_shift_c[DATA_W*8 +: DATA_W] = pix_in;
    end

    // State, position counters, window and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            state      <= state_nxt;
            win_valid  <= emit_c;
            frame_done <= last_c;
            if (pix_valid) begin
                win_data <= win_shift_c;
                if (col_end_c) begin
                    col <= '0;
                    row <= row_end_c ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (emit_c) begin
                win_row <= 5'(row) - 5'd2;
                win_col <= 5'(col) - 5'd2;
            end
        end
    end

    // Line buffers: the row above moves into lb0, the incoming pixel into lb1.
    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            lb0[col] <= lb1_rd_c;
            lb1[col] <= pix_in;
        end
    end

`ifdef CONV_WIN_CNT_EN
    // Per-frame window counter with a sticky count-mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
            cnt_err <= 1'b0;
        end else begin
            if (frame_done) begin
                win_cnt <= '0;
                if ((win_cnt + 10'd1) != 10'(N_WIN)) begin
                    cnt_err <= 1'b1;
                end
            end else if (win_valid) begin
                win_cnt <= win_cnt + 10'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3 at default parameters. A reference
// model builds every frame as a plain image array and enumerates the expected
// windows in raster order; a monitor compares each emitted window against it.
module tb_conv_window_3x3;

    localparam int W = 28;
    localparam int H = 28;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           pix_valid = 1'b0;
    logic [D-1:0]   pix_in = '0;
    logic           win_valid;
    logic [9*D-1:0] win_data;
    logic [4:0]     win_row;
    logic [4:0]     win_col;
    logic           frame_done;
`ifdef CONV_WIN_CNT_EN
    logic [9:0]     win_cnt;
    logic           cnt_err;
`endif

    conv_window_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .win_valid  (win_valid),
        .win_data   (win_data),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
`ifdef CONV_WIN_CNT_EN
        ,
        .win_cnt    (win_cnt),
        .cnt_err    (cnt_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9*D-1:0] d;
        logic [4:0]     r;
        logic [4:0]     c;
        logic           fd;
    } win_t;

    win_t       exp_q[$];
    logic [7:0] stim_q[$];
    win_t       mon_w;

    int n_checks = 0;
    int n_errors = 0;
    int n_win    = 0;
    int n_fd     = 0;
    logic [9*D-1:0] first_win;
    logic [9*D-1:0] last_win;
    logic pv_q = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: queue the first npix pixels of a frame and every
    // window whose bottom-right pixel lies among them.
    task automatic expect_frame(input bit rnd, input int off, input int npix);
        logic [7:0]     img [W*H];
        logic [9*D-1:0] d;
        win_t           w;
        for (int i = 0; i < W*H; i++) begin
            img[i] = rnd ? 8'($urandom) : 8'(i + off);
        end
        for (int i = 0; i < npix; i++) stim_q.push_back(img[i]);
        for (int rr = 2; rr < H; rr++) begin
            for (int cc = 2; cc < W; cc++) begin
                if (rr*W + cc < npix) begin
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            d[D*(3*r+c) +: D] = img[(rr-2+r)*W + (cc-2+c)];
                    w.d  = d;
                    w.r  = 5'(rr - 2);
                    w.c  = 5'(cc - 2);
                    w.fd = (rr == H-1) && (cc == W-1);
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    // Feed all queued pixels with roughly duty% pix_valid occupancy.
    task automatic drive(input int duty, input bit idle_end);
        while (stim_q.size() > 0) begin
            @(negedge clk);
            if ($urandom_range(99) < duty) begin
                pix_valid = 1'b1;
                pix_in    = stim_q.pop_front();
            end else begin
                pix_valid = 1'b0;
                pix_in    = 8'($urandom);
            end
        end
        if (idle_end) begin
            @(negedge clk);
            pix_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    always @(posedge clk) pv_q <= pix_valid & ~rst;

    // Compare every emitted window against the model, in order.
    always @(negedge clk) begin
        if (win_valid) begin
            check("valid_after_gap", 128'(pv_q), 128'(1));
            if (exp_q.size() == 0) begin
                check("extra_window", 128'(1), 128'(0));
            end else begin
                mon_w = exp_q.pop_front();
                check("win_data", 128'(win_data), 128'(mon_w.d));
                check("win_row", 128'(win_row), 128'(mon_w.r));
                check("win_col", 128'(win_col), 128'(mon_w.c));
                check("frame_done", 128'(frame_done), 128'(mon_w.fd));
            end
            n_win++;
            if (win_row == 5'd0 && win_col == 5'd0) first_win = win_data;
            if (frame_done) begin
                last_win = win_data;
                n_fd++;
`ifdef CONV_WIN_CNT_EN
                check("win_cnt_at_done", 128'(win_cnt), 128'(675));
                check("cnt_err", 128'(cnt_err), 128'(0));
`endif
            end
        end else if (frame_done) begin
            check("fd_without_valid", 128'(1), 128'(0));
        end
    end

    initial begin
        int base_w;
        int base_f;

        repeat (3) @(negedge clk);
        check("rst_win_valid", 128'(win_valid), 128'(0));
        check("rst_frame_done", 128'(frame_done), 128'(0));
        check("rst_win_data", 128'(win_data), 128'(0));
        check("rst_win_row", 128'(win_row), 128'(0));
        check("rst_win_col", 128'(win_col), 128'(0));
        rst = 1'b0;

        // Ramp frame, no gaps.
        base_w = n_win; base_f = n_fd;
        expect_frame(1'b0, 0, W*H);
        drive(100, 1'b1);
        check("ramp_count", 128'(n_win - base_w), 128'(676));
        check("ramp_fd_count", 128'(n_fd - base_f), 128'(1));
        check("ramp_first", 128'(first_win),
              128'({8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0}));
        check("ramp_last", 128'(last_win),
              128'({8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213}));

        // Ramp frame with ~40% pix_valid duty.
        base_w = n_win;
        expect_frame(1'b0, 0, W*H);
        drive(40, 1'b1);
        check("gappy_count", 128'(n_win - base_w), 128'(676));

        // Two back-to-back frames with different offsets.
        base_w = n_win; base_f = n_fd;
        expect_frame(1'b0, 16, W*H);
        expect_frame(1'b0, 128, W*H);
        drive(100, 1'b1);
        check("b2b_count", 128'(n_win - base_w), 128'(1352));
        check("b2b_fd_count", 128'(n_fd - base_f), 128'(2));

        // Random pixel data with ~60% duty.
        base_w = n_win;
        expect_frame(1'b1, 0, W*H);
        drive(60, 1'b1);
        check("rand_count", 128'(n_win - base_w), 128'(676));

        // Reset at pixel 400 (that pixel is dropped), then a clean frame.
        expect_frame(1'b0, 0, 400);
        drive(100, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        pix_valid = 1'b1;
        pix_in    = 8'hAA;
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b0;
        check("rst_mid_valid", 128'(win_valid), 128'(0));
        check("rst_mid_queue", 128'(exp_q.size()), 128'(0));
        base_w = n_win; base_f = n_fd;
        expect_frame(1'b0, 0, W*H);
        drive(100, 1'b1);
        check("post_rst_count", 128'(n_win - base_w), 128'(676));
        check("post_rst_fd", 128'(n_fd - base_f), 128'(1));

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
